// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM states, grant codes,
// default memory latency and the latched request record.
package mem_arb_pkg;

    localparam int MEM_LAT_DEFAULT = 2;
    localparam int CNT_W           = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_DMA  = 2'b10
    } grant_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/arb_select.sv
// Combinational winner selection between CPU and DMA requests.
// ARB_ROUND_ROBIN_EN: ties go to the master not granted last; otherwise CPU wins ties.
module arb_select
    import mem_arb_pkg::*;
(
    input  logic   cpu_req_i,
    input  logic   dma_req_i,
    input  logic   last_dma_i,
    output grant_e grant_o
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_o = GNT_NONE;
        if (cpu_req_i && dma_req_i) begin
            grant_o = last_dma_i ? GNT_CPU : GNT_DMA;
        end else if (cpu_req_i) begin
            grant_o = GNT_CPU;
        end else if (dma_req_i) begin
            grant_o = GNT_DMA;
        end
    end
`else
    // Fixed priority has no history, so the last-grant input is intentionally ignored.
    logic unused_last_dma;
    assign unused_last_dma = last_dma_i;

    always_comb begin
        grant_o = GNT_NONE;
        if (cpu_req_i) begin
            grant_o = GNT_CPU;
        end else if (dma_req_i) begin
            grant_o = GNT_DMA;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (CPU/DMA) single-port memory arbiter, one transaction in flight.
// ARB_ROUND_ROBIN_EN selects alternating tie-break; default is CPU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCpuReq,
    input  logic        iCpuWe,
    input  logic [31:0] iCpuAddr,
    input  logic [31:0] iCpuWData,
    output logic [31:0] oCpuRData,
    output logic        oCpuReady,
    input  logic        iDmaReq,
    input  logic        iDmaWe,
    input  logic [31:0] iDmaAddr,
    input  logic [31:0] iDmaWData,
    output logic [31:0] oDmaRData,
    output logic        oDmaReady,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    output logic        oMemWe,
    output logic        oMemRe,
    input  logic [31:0] iMemRData,
    output logic [1:0]  oGrant
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    grant_e           gnt_q, gnt_d;
    mem_req_t         req_q, req_d;
    logic             mem_we_q, mem_we_d;
    logic             mem_re_q, mem_re_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             cpu_rdy_q, cpu_rdy_d;
    logic             dma_rdy_q, dma_rdy_d;
    logic [31:0]      cpu_rdata_q, cpu_rdata_d;
    logic [31:0]      dma_rdata_q, dma_rdata_d;
    logic             last_dma;
    grant_e           sel;
    mem_req_t         win;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dma_q, last_dma_d;
    assign last_dma = last_dma_q;
`else
    assign last_dma = 1'b0;
`endif

    arb_select u_arb_select (
        .cpu_req_i  (iCpuReq),
        .dma_req_i  (iDmaReq),
        .last_dma_i (last_dma),
        .grant_o    (sel)
    );

    always_comb begin
        if (sel == GNT_DMA) begin
            win.we    = iDmaWe;
            win.addr  = iDmaAddr;
            win.wdata = iDmaWData;
        end else begin
            win.we    = iCpuWe;
            win.addr  = iCpuAddr;
            win.wdata = iCpuWData;
        end
    end

    // All outputs are registered, so each branch computes what the next cycle shows.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        req_d       = req_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        cpu_rdy_d   = 1'b0;
        dma_rdy_d   = 1'b0;
        cpu_rdata_d = '0;
        dma_rdata_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_dma_d  = last_dma_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sel != GNT_NONE) begin
                    state_d     = ST_BUSY;
                    gnt_d       = sel;
                    req_d       = win;
                    cnt_d       = CNT_W'(MEM_LAT);
                    mem_we_d    = win.we;
                    mem_re_d    = ~win.we;
                    mem_addr_d  = win.addr;
                    mem_wdata_d = win.wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    last_dma_d  = (sel == GNT_DMA);
`endif
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = ST_RESP;
                    cpu_rdy_d = (gnt_q == GNT_CPU);
                    dma_rdy_d = (gnt_q == GNT_DMA);
                    if (!req_q.we) begin
                        if (gnt_q == GNT_CPU) begin
                            cpu_rdata_d = iMemRData;
                        end else begin
                            dma_rdata_d = iMemRData;
                        end
                    end
                end else begin
                    mem_re_d    = ~req_q.we;
                    mem_addr_d  = req_q.addr;
                    mem_wdata_d = req_q.wdata;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gnt_q       <= GNT_NONE;
            req_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdy_q   <= 1'b0;
            dma_rdy_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dma_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            req_q       <= req_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdy_q   <= cpu_rdy_d;
            dma_rdy_q   <= dma_rdy_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_dma_q  <= last_dma_d;
`endif
        end
    end

    assign oCpuRData = cpu_rdata_q;
    assign oCpuReady = cpu_rdy_q;
    assign oDmaRData = dma_rdata_q;
    assign oDmaReady = dma_rdy_q;
    assign oMemAddr  = mem_addr_q;
    assign oMemWData = mem_wdata_q;
    assign oMemWe    = mem_we_q;
    assign oMemRe    = mem_re_q;
    assign oGrant    = gnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: main instance at MEM_LAT=2 plus MEM_LAT=1/7 instances.
module tb_mem_arbiter;

    localparam logic [31:0] RD_BASE = 32'h1234_5678;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_rdy, dma_rdy, mem_we, mem_re;
    logic [1:0]  gnt;

    // Memory returns a value derived from the address while a read is on the port.
    assign mem_rdata = mem_re ? (RD_BASE ^ mem_addr) : 32'hDEAD_BEEF;

    mem_arbiter #(.MEM_LAT(2)) u_dut (
        .iCLK(clk), .iRST(rst),
        .iCpuReq(cpu_req), .iCpuWe(cpu_we), .iCpuAddr(cpu_addr), .iCpuWData(cpu_wdata),
        .oCpuRData(cpu_rdata), .oCpuReady(cpu_rdy),
        .iDmaReq(dma_req), .iDmaWe(dma_we), .iDmaAddr(dma_addr), .iDmaWData(dma_wdata),
        .oDmaRData(dma_rdata), .oDmaReady(dma_rdy),
        .oMemAddr(mem_addr), .oMemWData(mem_wdata), .oMemWe(mem_we), .oMemRe(mem_re),
        .iMemRData(mem_rdata), .oGrant(gnt)
    );

    logic [31:0] l_cpu_rdata [2];
    logic [31:0] l_dma_rdata [2];
    logic [31:0] l_addr [2];
    logic [31:0] l_wdata [2];
    logic [31:0] l_rdata [2];
    logic [1:0]  l_gnt [2];
    logic [1:0]  l_cpu_rdy, l_dma_rdy, l_we, l_re, l_zero;

    for (genvar i = 0; i < 2; i++) begin : g_lat
        mem_arbiter #(.MEM_LAT(i == 0 ? 1 : 7)) u_lat (
            .iCLK(clk), .iRST(rst),
            .iCpuReq(cpu_req), .iCpuWe(cpu_we), .iCpuAddr(cpu_addr), .iCpuWData(cpu_wdata),
            .oCpuRData(l_cpu_rdata[i]), .oCpuReady(l_cpu_rdy[i]),
            .iDmaReq(dma_req), .iDmaWe(dma_we), .iDmaAddr(dma_addr), .iDmaWData(dma_wdata),
            .oDmaRData(l_dma_rdata[i]), .oDmaReady(l_dma_rdy[i]),
            .oMemAddr(l_addr[i]), .oMemWData(l_wdata[i]), .oMemWe(l_we[i]), .oMemRe(l_re[i]),
            .iMemRData(l_rdata[i]), .oGrant(l_gnt[i])
        );
        assign l_rdata[i] = l_re[i] ? (RD_BASE ^ l_addr[i]) : 32'hDEAD_BEEF;
        assign l_zero[i]  = ~|{l_cpu_rdata[i], l_dma_rdata[i], l_addr[i], l_wdata[i],
                               l_we[i], l_re[i], l_cpu_rdy[i], l_dma_rdy[i], l_gnt[i]};
    end

    typedef struct {
        logic        dma;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          err_cnt = 0;
    int          chk_cnt = 0;
    bit          mon_en  = 1'b0;
    int          we_cnt  = 0;
    int          re_cnt  = 0;
    logic [31:0] we_addr = '0;
    logic [31:0] we_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
                we_data = mem_wdata;
            end
            if (mem_re) re_cnt++;
            if (cpu_rdy || dma_rdy) begin
                if (sb.size() == 0) begin
                    chk("unexp_rdy", 32'({cpu_rdy, dma_rdy}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rdy_who", 32'({cpu_rdy, dma_rdy}), e.dma ? 32'd1 : 32'd2);
                    chk("rdata", e.dma ? dma_rdata : cpu_rdata, e.rdata);
                    chk("other_rdata", e.dma ? cpu_rdata : dma_rdata, 32'd0);
                end
            end
        end
    end

    task automatic push_exp(input bit dma, input bit we, input logic [31:0] addr);
        exp_t e;
        e.dma   = dma;
        e.rdata = we ? 32'd0 : (RD_BASE ^ addr);
        sb.push_back(e);
    endtask

    task automatic wait_rdy(input bit dma);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dma ? dma_rdy : cpu_rdy) && n < 40);
        chk("rdy_seen", dma ? dma_rdy : cpu_rdy, 1);
    endtask

    task automatic do_txn(input bit dma, input bit we, input logic [31:0] addr, input logic [31:0] wd);
        push_exp(dma, we, addr);
        if (dma) begin
            dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wd;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        wait_rdy(dma);
        if (dma) dma_req = 0; else cpu_req = 0;
    endtask

    task automatic do_rst();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat_m, lat_1, lat_7, we0, re0, got, n, seen;
        logic [31:0] l1_data, l7_data, addr2;
        logic [2:0]  re_pat, rdy_pat;
        logic [1:0]  gnt1;

        rst = 1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_strobes", 32'({cpu_rdy, dma_rdy, mem_we, mem_re}), 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_lat_zero", l_zero, 2'b11);
        rst = 0;
        @(negedge clk);
        chk("idle_noreq", 32'({gnt, mem_we, mem_re, cpu_rdy, dma_rdy}), 0);

        // Latency across MEM_LAT = 2, 1, 7 from the same CPU read.
        lat_m = 0; lat_1 = 0; lat_7 = 0; l1_data = '0; l7_data = '0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (cpu_rdy && lat_m == 0) lat_m = k;
            if (l_cpu_rdy[0] && lat_1 == 0) begin lat_1 = k; l1_data = l_cpu_rdata[0]; end
            if (l_cpu_rdy[1] && lat_7 == 0) begin lat_7 = k; l7_data = l_cpu_rdata[1]; end
        end
        cpu_req = 0;
        chk("lat2_cycle", lat_m, 3);
        chk("lat1_cycle", lat_1, 2);
        chk("lat7_cycle", lat_7, 8);
        chk("lat1_rdata", l1_data, RD_BASE);
        chk("lat7_rdata", l7_data, RD_BASE);
        do_rst();
        mon_en = 1;

        // Cycle-accurate CPU read; inputs change mid-BUSY and must be ignored.
        push_exp(0, 0, 32'h0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
        re_pat = '0; rdy_pat = '0; gnt1 = '0; addr2 = '1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            re_pat[k-1]  = mem_re;
            rdy_pat[k-1] = cpu_rdy;
            if (k == 1) begin gnt1 = gnt; cpu_addr = 32'h999; cpu_we = 1; end
            if (k == 2) addr2 = mem_addr;
        end
        cpu_req = 0; cpu_we = 0;
        chk("rd_re_cycles", re_pat, 3'b011);
        chk("rd_rdy_cycle", rdy_pat, 3'b100);
        chk("rd_grant", gnt1, 2'b01);
        chk("rd_addr_held", addr2, 0);

        // DMA write: exactly one write strobe, no read strobe.
        we0 = we_cnt; re0 = re_cnt;
        do_txn(1, 1, 32'h100, 32'hCAFE_BABE);
        chk("wr_we_pulses", we_cnt - we0, 1);
        chk("wr_addr", we_addr, 32'h100);
        chk("wr_data", we_data, 32'hCAFE_BABE);
        chk("wr_no_re", re_cnt - re0, 0);

        do_txn(0, 1, 32'h200, 32'h5555_AAAA);
        do_txn(1, 0, 32'h300, 32'h0);
        do_txn(0, 0, 32'hFFFF_FFFC, 32'h0);

        // Reset in the second BUSY cycle aborts the read.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44;
        @(negedge clk);
        @(negedge clk);
        rst = 1; cpu_req = 0;
        @(negedge clk);
        rst = 0;
        chk("abort_gnt", gnt, 0);
        chk("abort_re", mem_re, 0);
        seen = cpu_rdy ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_rdy) seen++;
        end
        chk("abort_no_rdy", seen, 0);
        do_txn(0, 0, 32'h44, 32'h0);

        // Both masters requesting continuously, then CPU drops out.
        do_rst();
`ifdef ARB_ROUND_ROBIN_EN
        push_exp(0, 0, 32'h40); push_exp(1, 0, 32'h80);
        push_exp(0, 0, 32'h40); push_exp(1, 0, 32'h80);
`else
        push_exp(0, 0, 32'h40); push_exp(0, 0, 32'h40);
        push_exp(0, 0, 32'h40); push_exp(0, 0, 32'h40);
`endif
        push_exp(1, 0, 32'h80);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        dma_req = 1; dma_we = 0; dma_addr = 32'h80;
        got = 0; n = 0;
        while (got < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (cpu_rdy || dma_rdy) got++;
        end
        cpu_req = 0;
        chk("cont_grants", got, 4);
        wait_rdy(1);
        dma_req = 0;
        repeat (3) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
